id_issue_queue: RTL and testbench

- Decoupling instruction queue between id_stage and issue_stage, on lane 0 of the decode/issue handshake.
- Buffers decoded scoreboard entries, the original instruction word and the control-flow flag.
- Presents the oldest entry to the scoreboard's decoded_instr_valid/ack interface.
- Throttles in-flight control-flow instructions, supports flush and accelerator-dispatcher stall, and exports occupancy to perf counters.

---
 rtl/id_issue_queue_pkg.sv | 18 +
 rtl/id_issue_queue.sv | 139 +++++++++++++
 tb/tb_id_issue_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_issue_queue_pkg.sv
// Shared constants and configuration types for the decode-to-issue queue.
package id_issue_queue_pkg;

    localparam int unsigned ID_ISSUE_QUEUE_DEPTH  = 4;
    localparam int unsigned ID_ISSUE_QUEUE_MAX_CF = 1;

    // Minimal core configuration: only the issue-port count matters here.
    typedef struct packed {
        int unsigned nr_issue_ports;
    } cva6_cfg_t;

    localparam cva6_cfg_t CVA6_CFG_EMPTY = '{nr_issue_ports: 32'd1};

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/id_issue_queue.sv
// Decoupling queue between decode and issue on lane 0: buffers decoded entries,
// throttles resident control-flow instructions and reports occupancy.
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg            = CVA6_CFG_EMPTY,
    parameter type         scoreboard_entry_t = logic,
    parameter int unsigned DEPTH              = ID_ISSUE_QUEUE_DEPTH,
    parameter int unsigned MAX_CF             = ID_ISSUE_QUEUE_MAX_CF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      stall_i,
    input  scoreboard_entry_t         decoded_instr_i,
    input  logic [31:0]               orig_instr_i,
    input  logic                      is_ctrl_flow_i,
    input  logic                      decoded_instr_valid_i,
    output logic                      decoded_instr_ack_o,
    output scoreboard_entry_t         issue_instr_o,
    output logic [31:0]               issue_orig_instr_o,
    output logic                      issue_is_ctrl_flow_o,
    output logic                      issue_instr_valid_o,
    input  logic                      issue_instr_ack_i,
    output logic [$clog2(DEPTH):0]    occupancy_o,
    output logic                      full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CF_W  = $clog2(MAX_CF) + 1;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic [31:0]       instr;
        logic              cf;
    } iq_entry_t;

    if (CVA6Cfg.nr_issue_ports < 1 || DEPTH < 2 || !is_pow2(DEPTH) ||
        MAX_CF < 1 || MAX_CF > DEPTH) begin : g_bad_cfg
        $error("id_issue_queue: unsupported parameter combination");
    end

    iq_entry_t              mem_q [DEPTH];
    iq_entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CF_W-1:0]        cf_cnt_q, cf_cnt_d;

    iq_entry_t              head;
    logic                   valid;
    logic                   pop;
    logic                   head_cf_pop;
    logic                   push_ok;
    logic                   push;

    // Handshake decisions and next-state computation.
    always_comb begin
        head = '0;
        if (count_q != '0) begin
            head = mem_q[rd_ptr_q];
        end
        valid       = (count_q != '0) & ~stall_i & ~flush_i;
        pop         = valid & issue_instr_ack_i;
        head_cf_pop = pop & head.cf;

        push_ok = 1'b1;
        if (flush_i) begin
            push_ok = 1'b0;
        end
        if ((count_q == CNT_W'(DEPTH)) && !pop) begin
            push_ok = 1'b0;
        end
        // A control-flow push may only reuse the slot freed by a control-flow pop.
        if (is_ctrl_flow_i && (cf_cnt_q == CF_W'(MAX_CF)) && !head_cf_pop) begin
            push_ok = 1'b0;
        end
        push = decoded_instr_valid_i & push_ok;

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        cf_cnt_d = cf_cnt_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            cf_cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{sbe: decoded_instr_i, instr: orig_instr_i, cf: is_ctrl_flow_i};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            cf_cnt_d = cf_cnt_q + CF_W'(push & is_ctrl_flow_i) - CF_W'(head_cf_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    assign decoded_instr_ack_o  = push;
    assign issue_instr_valid_o  = valid;
    assign issue_instr_o        = head.sbe;
    assign issue_orig_instr_o   = head.instr;
    assign issue_is_ctrl_flow_o = head.cf;
    assign occupancy_o          = count_q;
    assign full_o               = (count_q == CNT_W'(DEPTH));

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));
    a_cf_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        cf_cnt_q <= CF_W'(MAX_CF));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> (count_q != '0));
    a_push_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (decoded_instr_valid_i && !decoded_instr_ack_o) |=> $stable(decoded_instr_i));
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue with a queue-based reference model.
module tb_id_issue_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAX_CF = 1;

    typedef logic [31:0] sbe_t;
    typedef struct {
        sbe_t        sbe;
        logic [31:0] instr;
        logic        cf;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        stall_i;
    sbe_t        decoded_instr_i;
    logic [31:0] orig_instr_i;
    logic        is_ctrl_flow_i;
    logic        decoded_instr_valid_i;
    logic        decoded_instr_ack_o;
    sbe_t        issue_instr_o;
    logic [31:0] issue_orig_instr_o;
    logic        issue_is_ctrl_flow_o;
    logic        issue_instr_valid_o;
    logic        issue_instr_ack_i;
    logic [2:0]  occupancy_o;
    logic        full_o;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;
    ent_t q[$];

    always #5 clk_i = ~clk_i;

    id_issue_queue #(
        .scoreboard_entry_t (sbe_t),
        .DEPTH              (DEPTH),
        .MAX_CF             (MAX_CF)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .stall_i               (stall_i),
        .decoded_instr_i       (decoded_instr_i),
        .orig_instr_i          (orig_instr_i),
        .is_ctrl_flow_i        (is_ctrl_flow_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_instr_o         (issue_instr_o),
        .issue_orig_instr_o    (issue_orig_instr_o),
        .issue_is_ctrl_flow_o  (issue_is_ctrl_flow_o),
        .issue_instr_valid_o   (issue_instr_valid_o),
        .issue_instr_ack_i     (issue_instr_ack_i),
        .occupancy_o           (occupancy_o),
        .full_o                (full_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries, checked on every falling edge.
    always @(negedge clk_i) begin : model
        int   n;
        int   ncf;
        ent_t h;
        logic ev, ep, eok, ea;
        if (rst_i) begin
            q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            n   = q.size();
            h   = '{sbe: '0, instr: '0, cf: 1'b0};
            if (n != 0) h = q[0];
            ncf = 0;
            foreach (q[i]) if (q[i].cf) ncf++;
            ev  = (n != 0) && !stall_i && !flush_i;
            ep  = ev && issue_instr_ack_i;
            eok = !flush_i && !(n == DEPTH && !ep) &&
                  !(is_ctrl_flow_i && ncf >= MAX_CF && !(ep && h.cf));
            ea  = decoded_instr_valid_i && eok;
            check("m_valid", 64'(issue_instr_valid_o), 64'(ev));
            check("m_ack", 64'(decoded_instr_ack_o), 64'(ea));
            check("m_occ", 64'(occupancy_o), 64'(n));
            check("m_full", 64'(full_o), 64'(n == DEPTH));
            check("m_sbe", 64'(issue_instr_o), 64'(h.sbe));
            check("m_instr", 64'(issue_orig_instr_o), 64'(h.instr));
            check("m_cf", 64'(issue_is_ctrl_flow_o), 64'(h.cf));
            if (flush_i) begin
                q.delete();
            end else begin
                if (ep) void'(q.pop_front());
                if (ea) q.push_back('{sbe: decoded_instr_i, instr: orig_instr_i, cf: is_ctrl_flow_i});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input sbe_t s, input logic [31:0] ins, input logic cf);
        decoded_instr_valid_i = v;
        decoded_instr_i       = s;
        orig_instr_i          = ins;
        is_ctrl_flow_i        = cf;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; issue_instr_ack_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        cyc(); cyc();
        rst_i = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("idle_valid", 64'(issue_instr_valid_o), 64'd0);
            check("idle_ack", 64'(decoded_instr_ack_o), 64'd0);
            check("idle_occ", 64'(occupancy_o), 64'd0);
            check("idle_full", 64'(full_o), 64'd0);
            cyc();
        end

        // Fill to DEPTH, then swap head with a pending push.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sbe_t'(32'h100 + i), 32'h1000 + i, 1'b0);
            @(negedge clk_i);
            check("fill_ack", 64'(decoded_instr_ack_o), 64'd1);
            cyc();
        end
        drive(1'b1, 32'h104, 32'h1004, 1'b0);
        @(negedge clk_i);
        check("full_ack", 64'(decoded_instr_ack_o), 64'd0);
        check("full_flag", 64'(full_o), 64'd1);
        check("full_occ", 64'(occupancy_o), 64'd4);
        cyc();
        issue_instr_ack_i = 1'b1;
        @(negedge clk_i);
        check("swap_ack", 64'(decoded_instr_ack_o), 64'd1);
        check("swap_head", 64'(issue_orig_instr_o), 64'h1000);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk_i);
            if (i == 1) check("swap_occ", 64'(occupancy_o), 64'd4);
            check("drain_order", 64'(issue_orig_instr_o), 64'(32'h1000 + i));
            cyc();
        end
        issue_instr_ack_i = 1'b0;

        // Control-flow throttle with MAX_CF = 1.
        drive(1'b1, 32'h80, 32'h0000_0063, 1'b1);
        @(negedge clk_i);
        check("br_ack", 64'(decoded_instr_ack_o), 64'd1);
        cyc();
        drive(1'b1, 32'h84, 32'h0000_006F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("jal_blocked", 64'(decoded_instr_ack_o), 64'd0);
            cyc();
        end
        issue_instr_ack_i = 1'b1;
        @(negedge clk_i);
        check("br_head", 64'(issue_instr_o), 64'h80);
        check("jal_ack_on_pop", 64'(decoded_instr_ack_o), 64'd1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk_i);
        check("jal_head", 64'(issue_instr_o), 64'h84);
        check("jal_occ", 64'(occupancy_o), 64'd1);
        cyc();
        issue_instr_ack_i = 1'b0;

        // Flush with simultaneous push and pop requests.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sbe_t'(32'h200 + i), 32'h2000 + i, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h2FF, 32'h20FF, 1'b0);
        flush_i = 1'b1; issue_instr_ack_i = 1'b1;
        @(negedge clk_i);
        check("flush_ack", 64'(decoded_instr_ack_o), 64'd0);
        check("flush_valid", 64'(issue_instr_valid_o), 64'd0);
        cyc();
        flush_i = 1'b0; issue_instr_ack_i = 1'b0;
        @(negedge clk_i);
        check("flush_occ", 64'(occupancy_o), 64'd0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk_i);
        check("post_flush_head", 64'(issue_instr_o), 64'h2FF);
        check("post_flush_valid", 64'(issue_instr_valid_o), 64'd1);
        cyc();
        issue_instr_ack_i = 1'b1;
        cyc();
        issue_instr_ack_i = 1'b0;

        // Stall masks valid while pushes continue.
        stall_i = 1'b1; issue_instr_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 32'h300, 32'h00A0_0513, 1'b0);
            else if (i == 1) drive(1'b1, 32'h301, 32'h00B0_0593, 1'b0);
            else drive(1'b0, '0, '0, 1'b0);
            @(negedge clk_i);
            check("stall_valid", 64'(issue_instr_valid_o), 64'd0);
            if (i == 4) check("stall_occ", 64'(occupancy_o), 64'd2);
            cyc();
        end
        stall_i = 1'b0; issue_instr_ack_i = 1'b0;
        @(negedge clk_i);
        check("unstall_valid", 64'(issue_instr_valid_o), 64'd1);
        check("unstall_instr", 64'(issue_orig_instr_o), 64'h00A0_0513);
        cyc();
        issue_instr_ack_i = 1'b1;
        cyc(); cyc();
        issue_instr_ack_i = 1'b0;

        // Reset while full.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sbe_t'(32'h400 + i), 32'h4000 + i, 1'b1 & (i == 0));
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid", 64'(issue_instr_valid_o), 64'd0);
        check("rst_occ", 64'(occupancy_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_data", 64'(issue_orig_instr_o), 64'd0);
        cyc();

        // Nine push/pop pairs across pointer wrap.
        issue_instr_ack_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, sbe_t'(32'h500 + k), 32'h5000 + k, 1'b0);
            @(negedge clk_i);
            check("wrap_ack", 64'(decoded_instr_ack_o), 64'd1);
            if (k > 0) check("wrap_order", 64'(issue_orig_instr_o), 64'(32'h5000 + k - 1));
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk_i);
        check("wrap_last", 64'(issue_orig_instr_o), 64'h5008);
        cyc();
        issue_instr_ack_i = 1'b0;
        @(negedge clk_i);
        check("wrap_empty", 64'(occupancy_o), 64'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
